qproc_in_port_fifo: RTL and testbench

//  Input-port buffer ahead of the processor core's port-read path. Captures 64-bit

---
 rtl/qproc_in_port_fifo.sv | 130 +++++++++++++
 tb/tb_qproc_in_port_fifo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/qproc_in_port_fifo.sv
// Per-port input buffer for the core's port-read path: a registered head word per port
// backed by a small FIFO. Words arriving on a full port are dropped and counted.
module qproc_in_port_fifo #(
  parameter int IN_PORT_QTY = 1,
  parameter int PORT_AW     = 4,
  parameter int FIFO_AW     = 3
) (
  input  logic                      c_clk_i,
  input  logic                      c_rst_ni,
  input  logic                      restart_i,
  input  logic [IN_PORT_QTY-1:0]    in_vld_i,
  input  logic [64*IN_PORT_QTY-1:0] in_dt_i,
  input  logic                      port_re_i,
  input  logic [PORT_AW-1:0]        port_addr_i,
  input  logic [PORT_AW-1:0]        flag_sel_i,
  output logic [64*IN_PORT_QTY-1:0] port_dt_o,
  output logic [IN_PORT_QTY-1:0]    port_vld_o,
  output logic                      flag_o,
  output logic [IN_PORT_QTY-1:0]    ovf_o,
  output logic [15:0]               drop_cnt_o
);

  localparam int DEPTH = 2**FIFO_AW;
  localparam int NADDR = 2**PORT_AW;

  logic [IN_PORT_QTY-1:0] w_vld;
  logic [IN_PORT_QTY-1:0] w_drop;
  logic [IN_PORT_QTY-1:0] r_ovf;
  logic [15:0]            r_drop_cnt;
  logic [16:0]            w_drop_sum;
  logic [NADDR-1:0]       w_vld_pad;

  for (genvar k = 0; k < IN_PORT_QTY; k++) begin : g_port
    logic [63:0]        r_mem [DEPTH];
    logic [63:0]        r_head;
    logic               r_vld;
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_cnt;
    logic [63:0]        w_in_dt;
    logic               w_rd, w_in, w_empty, w_full;
    logic               w_load, w_pop, w_clr, w_push, w_drop_k;

    assign w_in_dt  = in_dt_i[64*k +: 64];
    assign w_in     = in_vld_i[k];
    assign w_rd     = port_re_i && (port_addr_i == PORT_AW'(k));
    assign w_empty  = (r_cnt == '0);
    assign w_full   = (r_cnt == (FIFO_AW+1)'(DEPTH));
    // The FIFO is only ever non-empty while the head is valid, so these cases are exclusive.
    assign w_load   = w_in & w_empty & (w_rd | ~r_vld);
    assign w_pop    = w_rd & ~w_empty;
    assign w_clr    = w_rd & w_empty & ~w_in;
    assign w_push   = w_in & (w_pop | (~w_rd & r_vld & ~w_full));
    assign w_drop_k = w_in & ~w_rd & r_vld & w_full;

    always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
      if (!c_rst_ni) begin
        r_head <= '0;
        r_vld  <= 1'b0;
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else if (restart_i) begin
        r_head <= '0;
        r_vld  <= 1'b0;
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_load) begin
          r_head <= w_in_dt;
          r_vld  <= 1'b1;
        end else if (w_pop) begin
          r_head <= r_mem[r_rptr];
        end else if (w_clr) begin
          r_vld  <= 1'b0;
        end
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + 1'b1;
          2'b01:   r_cnt <= r_cnt - 1'b1;
          default: r_cnt <= r_cnt;
        endcase
      end
    end

    // Push into a full FIFO only happens together with a pop, when wptr==rptr;
    // the pop sees the old word since the array write lands on the same edge.
    always_ff @(posedge c_clk_i) begin
      if (w_push) r_mem[r_wptr] <= w_in_dt;
    end

    assign port_dt_o[64*k +: 64] = r_head;
    assign w_vld[k]              = r_vld;
    assign w_drop[k]             = w_drop_k;
  end

  always_comb begin
    w_drop_sum = {1'b0, r_drop_cnt};
    for (int i = 0; i < IN_PORT_QTY; i++) begin
      w_drop_sum = w_drop_sum + 17'(w_drop[i]);
    end
  end

  always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
    if (!c_rst_ni) begin
      r_ovf      <= '0;
      r_drop_cnt <= '0;
    end else if (restart_i) begin
      r_ovf      <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_ovf      <= r_ovf | w_drop;
      r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  // Unimplemented port addresses read as not valid.
  always_comb begin
    w_vld_pad                  = '0;
    w_vld_pad[IN_PORT_QTY-1:0] = w_vld;
  end

  assign flag_o     = w_vld_pad[flag_sel_i];
  assign port_vld_o = w_vld;
  assign ovf_o      = r_ovf;
  assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_qproc_in_port_fifo.sv
// Directed bench for qproc_in_port_fifo with three ports and an 8-deep FIFO per port.
module tb_qproc_in_port_fifo;
  localparam int QTY = 3;
  localparam int PAW = 4;
  localparam int FAW = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              restart;
  logic [QTY-1:0]    in_vld;
  logic [64*QTY-1:0] in_dt;
  logic              port_re;
  logic [PAW-1:0]    port_addr;
  logic [PAW-1:0]    flag_sel;
  logic [64*QTY-1:0] port_dt;
  logic [QTY-1:0]    port_vld;
  logic              flag;
  logic [QTY-1:0]    ovf;
  logic [15:0]       drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  qproc_in_port_fifo #(.IN_PORT_QTY(QTY), .PORT_AW(PAW), .FIFO_AW(FAW)) dut (
    .c_clk_i     (clk),
    .c_rst_ni    (rst_n),
    .restart_i   (restart),
    .in_vld_i    (in_vld),
    .in_dt_i     (in_dt),
    .port_re_i   (port_re),
    .port_addr_i (port_addr),
    .flag_sel_i  (flag_sel),
    .port_dt_o   (port_dt),
    .port_vld_o  (port_vld),
    .flag_o      (flag),
    .ovf_o       (ovf),
    .drop_cnt_o  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] dt(input int k);
    return port_dt[64*k +: 64];
  endfunction

  task automatic read_port(input int k);
    port_re   = 1'b1;
    port_addr = PAW'(k);
    tick();
    port_re   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; restart = 1'b0; in_vld = '0; in_dt = '0;
    port_re = 1'b0; port_addr = '0; flag_sel = '0;
    #12;
    chk("rst_vld_async", 64'(port_vld), 64'h0);
    chk("rst_dt_async", 64'(port_dt[63:0]), 64'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_vld", 64'(port_vld), 64'h0);
    chk("rst_dt", 64'(port_dt[191:128]), 64'h0);
    chk("rst_ovf", 64'(ovf), 64'h0);
    chk("rst_drop", 64'(drop_cnt), 64'h0);
    chk("rst_flag", 64'(flag), 64'h0);

    // Single word latency and read-out
    in_vld[0] = 1'b1; in_dt[63:0] = 64'h1111_2222_3333_4444;
    tick();
    in_vld = '0;
    chk("t1_dt", dt(0), 64'h1111_2222_3333_4444);
    chk("t1_vld", 64'(port_vld[0]), 64'h1);
    tick();
    read_port(0);
    chk("t1_vld_after_rd", 64'(port_vld[0]), 64'h0);
    chk("t1_dt_held", dt(0), 64'h1111_2222_3333_4444);

    // Ten back-to-back words on port 1: nine stored, one dropped
    for (int i = 1; i <= 10; i++) begin
      in_vld[1] = 1'b1; in_dt[127:64] = 64'(i);
      tick();
    end
    in_vld = '0;
    chk("t2_ovf", 64'(ovf), 64'h2);
    chk("t2_drop", 64'(drop_cnt), 64'h1);
    for (int i = 1; i <= 10; i++) begin
      chk("t2_rd_dt", dt(1), (i <= 9) ? 64'(i) : 64'd9);
      chk("t2_rd_vld", 64'(port_vld[1]), (i <= 9) ? 64'h1 : 64'h0);
      read_port(1);
    end
    chk("t2_final_vld", 64'(port_vld[1]), 64'h0);

    // Full FIFO with simultaneous read and write: nothing lost
    for (int i = 0; i < 9; i++) begin
      in_vld[1] = 1'b1; in_dt[127:64] = 64'h100 + 64'(i);
      tick();
    end
    in_dt[127:64] = 64'h200; port_re = 1'b1; port_addr = 4'd1;
    tick();
    port_re = 1'b0;
    chk("t3_nodrop", 64'(drop_cnt), 64'h1);
    chk("t3_head", dt(1), 64'h101);
    in_dt[127:64] = 64'h300;
    tick();
    in_vld = '0;
    chk("t3_still_full", 64'(drop_cnt), 64'h2);
    for (int i = 0; i < 9; i++) begin
      chk("t3_order", dt(1), (i < 8) ? 64'h101 + 64'(i) : 64'h200);
      read_port(1);
    end
    chk("t3_empty_vld", 64'(port_vld[1]), 64'h0);
    chk("t3_stale_dt", dt(1), 64'h200);

    // Ports 0 and 2 overflow on the same cycle
    for (int i = 0; i < 9; i++) begin
      in_vld = 3'b101; in_dt[63:0] = 64'hA0 + 64'(i); in_dt[191:128] = 64'hC0 + 64'(i);
      tick();
    end
    in_dt[63:0] = 64'hEE; in_dt[191:128] = 64'hEF;
    tick();
    in_vld = '0;
    chk("t4_drop2", 64'(drop_cnt), 64'h4);
    chk("t4_ovf", 64'(ovf), 64'h7);

    // Flag select and out-of-range read
    flag_sel = 4'd2; #1;
    chk("t5_flag2", 64'(flag), 64'h1);
    flag_sel = 4'd1; #1;
    chk("t5_flag1", 64'(flag), 64'h0);
    flag_sel = 4'd5; #1;
    chk("t5_flag5", 64'(flag), 64'h0);
    read_port(7);
    chk("t5_addr7_dt0", dt(0), 64'hA0);
    chk("t5_addr7_dt2", dt(2), 64'hC0);
    chk("t5_addr7_vld", 64'(port_vld), 64'h5);
    chk("t5_addr7_drop", 64'(drop_cnt), 64'h4);
    read_port(2);
    chk("t5_port2_next", dt(2), 64'hC1);

    // Restart with concurrent pushes and a read
    flag_sel = 4'd2;
    restart = 1'b1; in_vld = 3'b111; in_dt = {3{64'hBAD}};
    port_re = 1'b1; port_addr = 4'd0;
    tick();
    restart = 1'b0; in_vld = '0; port_re = 1'b0;
    chk("t6_rs_vld", 64'(port_vld), 64'h0);
    chk("t6_rs_dt0", dt(0), 64'h0);
    chk("t6_rs_dt2", dt(2), 64'h0);
    chk("t6_rs_ovf", 64'(ovf), 64'h0);
    chk("t6_rs_drop", 64'(drop_cnt), 64'h0);
    chk("t6_rs_flag", 64'(flag), 64'h0);
    in_vld[2] = 1'b1; in_dt[191:128] = 64'hDEAD;
    tick();
    in_vld = '0;
    chk("t6_post_dt", dt(2), 64'hDEAD);
    read_port(2);
    chk("t6_post_empty", 64'(port_vld[2]), 64'h0);

    // Saturation of the drop counter
    restart = 1'b1;
    tick();
    restart = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_vld = 3'b111; in_dt = {3{64'(i)}};
      tick();
    end
    chk("t4_fill_nodrop", 64'(drop_cnt), 64'h0);
    for (int i = 0; i < 21844; i++) tick();
    chk("t4_cnt_fffc", 64'(drop_cnt), 64'hFFFC);
    in_vld = 3'b101;
    tick();
    chk("t4_cnt_fffe", 64'(drop_cnt), 64'hFFFE);
    tick();
    chk("t4_sat", 64'(drop_cnt), 64'hFFFF);
    in_vld = 3'b111;
    tick();
    chk("t4_sat_hold", 64'(drop_cnt), 64'hFFFF);

    // Asynchronous reset mid-stream
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_arst_vld", 64'(port_vld), 64'h0);
    chk("t6_arst_dt1", dt(1), 64'h0);
    chk("t6_arst_ovf", 64'(ovf), 64'h0);
    chk("t6_arst_drop", 64'(drop_cnt), 64'h0);
    in_vld = '0;
    #2;
    rst_n = 1'b1;
    tick();
    chk("t6_arst_after", 64'(port_vld), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
